// File: rtl/tracker_pkg.sv
// Shared constants and types for the per-frame centroid/radius scheduler.
package tracker_pkg;

  // Default widths and the r_sq scaling pair (7/22 approximates 1/pi).
  localparam int SIZE_W = 20;
  localparam int SUM_W  = 32;
  localparam int R_NUM  = 7;
  localparam int R_DEN  = 22;

  typedef enum logic [2:0] {
    IDLE,
    DIV_X,
    DIV_Y,
    DIV_R,
    PUBLISH,
    PUBLISH_NT
  } state_t;

  // Each DIV_* state issues the divider once, then waits for its done pulse.
  typedef enum logic {
    PH_ISSUE,
    PH_WAIT
  } phase_t;

  // Debug view of the scheduler: FSM state, phase and last divider remainder.
  typedef struct packed {
    state_t            state;
    phase_t            phase;
    logic [SUM_W-1:0]  div_rem;
  } dbg_t;

endpackage

// File: rtl/centroid_div_sched_if.sv
// Bus bundle between the blob accumulator, the scheduler and the overlay side.
// There is no valid/ready handshake here: vsync's falling edge is the only
// request, and done is a one-cycle strobe marking a coherent output update.
interface centroid_div_sched_if;
  import tracker_pkg::*;

  logic              vsync;
  logic [SIZE_W-1:0] size_in;
  logic [SUM_W-1:0]  sum_x_in;
  logic [SUM_W-1:0]  sum_y_in;
  logic [SUM_W-1:0]  x_center;
  logic [SUM_W-1:0]  y_center;
  logic [SUM_W-1:0]  r_sq;
  logic              no_target;
  logic              busy;
  logic              done;
  logic              overrun;
  dbg_t              dbg;

  modport master (
    output vsync, size_in, sum_x_in, sum_y_in,
    input  x_center, y_center, r_sq, no_target, busy, done, overrun, dbg
  );

  modport slave (
    input  vsync, size_in, sum_x_in, sum_y_in,
    output x_center, y_center, r_sq, no_target, busy, done, overrun, dbg
  );

endinterface

// File: rtl/serial_div.sv
// Restoring unsigned divider, one quotient bit per cycle.
// done pulses exactly W+1 cycles after the cycle in which start is sampled;
// quotient/remainder hold until the next start. start while running is ignored.
module serial_div #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_in,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  logic          running_q, running_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic          done_q, done_d;
  logic [W:0]    shifted;
  logic [W:0]    diff;

  // Next-state: load on start, then one shift/trial-subtract step per cycle.
  always_comb begin
    shifted   = {rem_q, quo_q[W-1]};
    diff      = shifted - {1'b0, dvs_q};
    running_d = running_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    done_d    = 1'b0;
    if (!running_q) begin
      if (start) begin
        running_d = 1'b1;
        cnt_d     = CW'(W);
        quo_d     = dividend;
        rem_d     = '0;
        dvs_d     = divisor;
      end
    end else begin
      // diff's top bit is the borrow: clear means the trial subtract fits.
      if (!diff[W]) begin
        rem_d = diff[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = shifted[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        running_d = 1'b0;
        done_d    = 1'b1;
      end
    end
  end

  // Register divider state with async active-low reset.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      running_q <= running_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      done_q    <= done_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = done_q;

endmodule

// File: rtl/centroid_div_sched.sv
// Per-frame scheduler: snapshots blob accumulators on vsync falling edge and
// computes x_center, y_center and r_sq through one shared serial divider.
// All three results update together on the done pulse.
module centroid_div_sched (
  input  logic                  clk,
  input  logic                  rst_in,
  centroid_div_sched_if.slave   bus
);
  import tracker_pkg::*;

  localparam logic [SUM_W-1:0] R_NUM_W = SUM_W'(R_NUM);
  localparam logic [SUM_W-1:0] R_DEN_W = SUM_W'(R_DEN);

  state_t            state_q, state_d;
  phase_t            phase_q, phase_d;
  logic              vsync_q;
  logic              fe;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [SUM_W-1:0]  sum_x_q, sum_x_d;
  logic [SUM_W-1:0]  sum_y_q, sum_y_d;
  logic [SUM_W-1:0]  xs_q, xs_d;
  logic [SUM_W-1:0]  ys_q, ys_d;
  logic [SUM_W-1:0]  x_center_q, x_center_d;
  logic [SUM_W-1:0]  y_center_q, y_center_d;
  logic [SUM_W-1:0]  r_sq_q, r_sq_d;
  logic              no_target_q, no_target_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;

  logic              div_start;
  logic [SUM_W-1:0]  div_dividend;
  logic [SUM_W-1:0]  div_divisor;
  logic [SUM_W-1:0]  div_quotient;
  logic [SUM_W-1:0]  div_rem;
  logic              div_done;
  logic [SUM_W-1:0]  size_ext;
  logic [SUM_W-1:0]  r_num_prod;

  assign fe         = vsync_q & ~bus.vsync;
  assign size_ext   = {{(SUM_W-SIZE_W){1'b0}}, size_q};
  // Fits in SUM_W bits for the default SIZE_W (max 786432*7).
  assign r_num_prod = size_ext * R_NUM_W;

  serial_div #(.W(SUM_W)) u_div (
    .clk       (clk),
    .rst_in    (rst_in),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .quotient  (div_quotient),
    .remainder (div_rem),
    .done      (div_done)
  );

  // Scheduler next-state: snapshot, three divides, then a coherent publish.
  // done is raised on the edge entering PUBLISH/PUBLISH_NT; busy stays high
  // through that cycle so a coinciding frame end is counted as an overrun.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    size_d       = size_q;
    sum_x_d      = sum_x_q;
    sum_y_d      = sum_y_q;
    xs_d         = xs_q;
    ys_d         = ys_q;
    x_center_d   = x_center_q;
    y_center_d   = y_center_q;
    r_sq_d       = r_sq_q;
    no_target_d  = no_target_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    overrun_d    = overrun_q | (fe & busy_q);
    div_start    = 1'b0;
    div_dividend = sum_x_q;
    div_divisor  = size_ext;
    case (state_q)
      IDLE: begin
        if (fe) begin
          size_d  = bus.size_in;
          sum_x_d = bus.sum_x_in;
          sum_y_d = bus.sum_y_in;
          busy_d  = 1'b1;
          phase_d = PH_ISSUE;
          if (bus.size_in == '0) begin
            state_d     = PUBLISH_NT;
            no_target_d = 1'b1;
            done_d      = 1'b1;
          end else begin
            state_d = DIV_X;
          end
        end
      end
      DIV_X: begin
        div_dividend = sum_x_q;
        div_divisor  = size_ext;
        if (phase_q == PH_ISSUE) begin
          div_start = 1'b1;
          phase_d   = PH_WAIT;
        end else if (div_done) begin
          xs_d    = div_quotient;
          state_d = DIV_Y;
          phase_d = PH_ISSUE;
        end
      end
      DIV_Y: begin
        div_dividend = sum_y_q;
        div_divisor  = size_ext;
        if (phase_q == PH_ISSUE) begin
          div_start = 1'b1;
          phase_d   = PH_WAIT;
        end else if (div_done) begin
          ys_d    = div_quotient;
          state_d = DIV_R;
          phase_d = PH_ISSUE;
        end
      end
      DIV_R: begin
        div_dividend = r_num_prod;
        div_divisor  = R_DEN_W;
        if (phase_q == PH_ISSUE) begin
          div_start = 1'b1;
          phase_d   = PH_WAIT;
        end else if (div_done) begin
          x_center_d  = xs_q;
          y_center_d  = ys_q;
          r_sq_d      = div_quotient;
          no_target_d = 1'b0;
          done_d      = 1'b1;
          state_d     = PUBLISH;
          phase_d     = PH_ISSUE;
        end
      end
      PUBLISH, PUBLISH_NT: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Single register bank for FSM, snapshots, shadows and outputs.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      phase_q     <= PH_ISSUE;
      vsync_q     <= 1'b0;
      size_q      <= '0;
      sum_x_q     <= '0;
      sum_y_q     <= '0;
      xs_q        <= '0;
      ys_q        <= '0;
      x_center_q  <= '0;
      y_center_q  <= '0;
      r_sq_q      <= '0;
      no_target_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      vsync_q     <= bus.vsync;
      size_q      <= size_d;
      sum_x_q     <= sum_x_d;
      sum_y_q     <= sum_y_d;
      xs_q        <= xs_d;
      ys_q        <= ys_d;
      x_center_q  <= x_center_d;
      y_center_q  <= y_center_d;
      r_sq_q      <= r_sq_d;
      no_target_q <= no_target_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.x_center  = x_center_q;
  assign bus.y_center  = y_center_q;
  assign bus.r_sq      = r_sq_q;
  assign bus.no_target = no_target_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.overrun   = overrun_q;
  assign bus.dbg       = '{state: state_q, phase: phase_q, div_rem: div_rem};

endmodule

// File: tb/tb_centroid_div_sched.sv
// Directed bench for centroid_div_sched: nominal, exact radius, empty frame,
// max operands, async reset mid-frame, frame end during publish, overrun.
module tb_centroid_div_sched;
  import tracker_pkg::*;

  logic clk;
  logic rst_in;
  int   n_assert;
  int   n_fail;
  int   lat;
  int   n_done;

  centroid_div_sched_if bus ();

  centroid_div_sched dut (
    .clk    (clk),
    .rst_in (rst_in),
    .bus    (bus)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Raise vsync for one cycle, then drop it: the drop cycle is the frame-end cycle.
  task automatic frame(input logic [19:0] sz, input logic [31:0] sx, input logic [31:0] sy);
    @(negedge clk);
    bus.vsync    = 1'b1;
    bus.size_in  = sz;
    bus.sum_x_in = sx;
    bus.sum_y_in = sy;
    @(negedge clk);
    bus.vsync    = 1'b0;
  endtask

  // Cycles from the frame-end cycle to the done cycle; -1 if it never comes.
  task automatic wait_done(output int l);
    l = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_in = 1'b1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".x_center"},  bus.x_center,  32'd0);
    check({tag, ".y_center"},  bus.y_center,  32'd0);
    check({tag, ".r_sq"},      bus.r_sq,      32'd0);
    check({tag, ".no_target"}, bus.no_target, 32'd0);
    check({tag, ".busy"},      bus.busy,      32'd0);
    check({tag, ".done"},      bus.done,      32'd0);
    check({tag, ".overrun"},   bus.overrun,   32'd0);
    check({tag, ".state"},     32'(bus.dbg.state), 32'(IDLE));
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    rst_in       = 1'b0;
    bus.vsync    = 1'b0;
    bus.size_in  = '0;
    bus.sum_x_in = '0;
    bus.sum_y_in = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    check("reset.div_rem", bus.dbg.div_rem, 32'd0);
    rst_in = 1'b1;

    // Nominal: 400/4, 200/4, 28/22
    frame(20'd4, 32'd400, 32'd200);
    @(negedge clk);
    check("nom.busy_early", bus.busy, 32'd1);
    check("nom.x_held", bus.x_center, 32'd0);
    wait_done(lat);
    check("nom.latency", lat + 1, 32'd103);
    check("nom.x_center", bus.x_center, 32'd100);
    check("nom.y_center", bus.y_center, 32'd50);
    check("nom.r_sq", bus.r_sq, 32'd1);
    check("nom.no_target", bus.no_target, 32'd0);
    check("nom.div_rem", bus.dbg.div_rem, 32'd6);
    @(negedge clk);
    check("nom.done_pulse", bus.done, 32'd0);
    check("nom.busy_after", bus.busy, 32'd0);
    check("nom.overrun", bus.overrun, 32'd0);

    // Empty frame: outputs hold, no_target set, done one cycle after frame end
    frame(20'd0, 32'd77, 32'd88);
    wait_done(lat);
    check("empty.latency", lat, 32'd1);
    check("empty.no_target", bus.no_target, 32'd1);
    check("empty.x_center", bus.x_center, 32'd100);
    check("empty.y_center", bus.y_center, 32'd50);
    check("empty.r_sq", bus.r_sq, 32'd1);

    // Radius exactness: 22*7/22 = 7
    frame(20'd22, 32'd14080, 32'd10560);
    wait_done(lat);
    check("rad.latency", lat, 32'd103);
    check("rad.x_center", bus.x_center, 32'd640);
    check("rad.y_center", bus.y_center, 32'd480);
    check("rad.r_sq", bus.r_sq, 32'd7);
    check("rad.no_target", bus.no_target, 32'd0);

    // Max operands: 4294967295/786432 = 5461, 5505024/22 = 250228
    frame(20'd786432, 32'hFFFF_FFFF, 32'd7864320);
    wait_done(lat);
    check("max.latency", lat, 32'd103);
    check("max.x_center", bus.x_center, 32'd5461);
    check("max.y_center", bus.y_center, 32'd10);
    check("max.r_sq", bus.r_sq, 32'd250228);

    // Async reset 60 cycles into a frame: everything clears immediately
    frame(20'd4, 32'd400, 32'd200);
    repeat (60) @(negedge clk);
    #2 rst_in = 1'b0;
    #1 check_cleared("midrst");
    @(negedge clk);
    rst_in = 1'b1;
    frame(20'd2, 32'd10, 32'd6);
    wait_done(lat);
    check("post.latency", lat, 32'd103);
    check("post.x_center", bus.x_center, 32'd5);
    check("post.y_center", bus.y_center, 32'd3);
    check("post.r_sq", bus.r_sq, 32'd0);
    check("post.overrun", bus.overrun, 32'd0);

    // Frame end in the publish cycle is dropped and flagged
    frame(20'd4, 32'd400, 32'd200);
    repeat (102) @(negedge clk);
    bus.vsync   = 1'b1;
    bus.size_in = 20'd9;
    @(negedge clk);
    check("coll.done", bus.done, 32'd1);
    check("coll.busy", bus.busy, 32'd1);
    bus.vsync = 1'b0;
    @(negedge clk);
    check("coll.overrun", bus.overrun, 32'd1);
    check("coll.busy_after", bus.busy, 32'd0);
    count_done(150, n_done);
    check("coll.extra_done", n_done, 32'd0);
    check("coll.x_center", bus.x_center, 32'd100);

    // Overrun: second frame end 50 cycles into the first
    do_reset();
    check("ovr.cleared", bus.overrun, 32'd0);
    frame(20'd8, 32'd800, 32'd1600);
    repeat (49) @(negedge clk);
    bus.vsync    = 1'b1;
    bus.size_in  = 20'd5;
    bus.sum_x_in = 32'd999;
    bus.sum_y_in = 32'd999;
    @(negedge clk);
    bus.vsync = 1'b0;
    @(negedge clk);
    check("ovr.flag", bus.overrun, 32'd1);
    wait_done(lat);
    check("ovr.latency", lat + 51, 32'd103);
    check("ovr.x_center", bus.x_center, 32'd100);
    check("ovr.y_center", bus.y_center, 32'd200);
    check("ovr.r_sq", bus.r_sq, 32'd2);
    count_done(150, n_done);
    check("ovr.extra_done", n_done, 32'd0);
    check("ovr.sticky", bus.overrun, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
